// File: rtl/state_unpack_mask_n_pkg.sv
// Shared constants, FSM encoding and packing helper for the Kyber two-share masking unit.
package kyber_mask_pkg;

  localparam int KYBER_Q_DEFAULT = 3329;

  localparam int MODE_ARITH = 0;
  localparam int MODE_BOOL  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MASK = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Coefficient 0 sits at the MSB end of the packed vector.
  function automatic int slot_off(input int idx, input int n_coef, input int coef_w);
    return n_coef * coef_w - 1 - idx * coef_w;
  endfunction

endpackage

// File: rtl/state_unpack_mask_n_mod_q_sub.sv
// (c - r) mod KYBER_Q by one conditional subtract; c and r are expected in [0, KYBER_Q).
module mod_q_sub
  import kyber_mask_pkg::*;
#(
  parameter int KYBER_Q = KYBER_Q_DEFAULT,
  parameter int COEF_W  = 16
) (
  input  logic [COEF_W-1:0] c_i,
  input  logic [COEF_W-1:0] r_i,
  output logic [COEF_W-1:0] d_o
);
  localparam int W = COEF_W + 2;
  localparam logic [W-1:0] Q_W = W'(KYBER_Q);

  logic [W-1:0] sum_s;
  logic [W-1:0] diff_s;

  // Bias by Q so the difference never goes negative, then fold back once.
  always_comb begin
    sum_s = {2'b00, c_i} + Q_W - {2'b00, r_i};
    if (sum_s >= Q_W) begin
      diff_s = sum_s - Q_W;
    end else begin
      diff_s = sum_s;
    end
    d_o = COEF_W'(diff_s);
  end

endmodule

// File: rtl/state_unpack_mask_n.sv
// Two-share masking of an N-coefficient packed Kyber state, one coefficient per
// accepted random word through a single shared datapath.
module state_unpack_mask_n
  import kyber_mask_pkg::*;
#(
  parameter int KYBER_Q = KYBER_Q_DEFAULT,
  parameter int COEF_W  = 16,
  parameter int N_COEF  = 8,
  parameter int RAND_W  = 16,
  parameter int MODE    = MODE_ARITH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [N_COEF*COEF_W-1:0] s,
  // "rand" is a SystemVerilog keyword, so the random word carries a suffix.
  input  logic [RAND_W-1:0]        rand_data,
  input  logic                     rand_valid,
  output logic                     rand_ready,
  output logic                     busy,
  output logic                     function_done,
  output logic [N_COEF*COEF_W-1:0] s1,
  output logic [N_COEF*COEF_W-1:0] s2,
  output logic                     range_err
);
  localparam int SW    = N_COEF * COEF_W;
  localparam int RB    = $clog2(KYBER_Q);
  localparam int IDX_W = (N_COEF > 1) ? $clog2(N_COEF) : 1;
  localparam int OFF_W = $clog2(SW);

  localparam logic [COEF_W-1:0] Q_C  = COEF_W'(KYBER_Q);
  localparam logic [IDX_W-1:0]  LAST = IDX_W'(N_COEF - 1);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] MASK = ST_MASK;
  localparam logic [1:0] DONE = ST_DONE;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SW-1:0]    s_reg_q, s_reg_d;
  logic [SW-1:0]    s1_q, s1_d;
  logic [SW-1:0]    s2_q, s2_d;
  logic             range_err_q, range_err_d;

  logic [OFF_W-1:0]  off_s;
  logic [COEF_W-1:0] coef_s;
  logic [COEF_W-1:0] coef_red_s;
  logic              coef_over_s;
  logic [COEF_W-1:0] r_cand_s;
  logic              r_accept_s;
  logic [COEF_W-1:0] d_arith_s;
  logic [COEF_W-1:0] s2_slot_s;
  logic              xfer_s;
  logic              unused_rand_s;

  assign unused_rand_s = ^rand_data;

  // Slot select, candidate screening and share-2 value for the current index.
  always_comb begin
    off_s       = OFF_W'(slot_off(int'(idx_q), N_COEF, COEF_W));
    coef_s      = s_reg_q[off_s -: COEF_W];
    coef_over_s = (coef_s >= Q_C);
    if (coef_over_s) begin
      coef_red_s = coef_s - Q_C;
    end else begin
      coef_red_s = coef_s;
    end
    if (MODE == MODE_BOOL) begin
      r_cand_s   = rand_data[COEF_W-1:0];
      r_accept_s = 1'b1;
      s2_slot_s  = coef_s ^ r_cand_s;
    end else begin
      r_cand_s   = {{(COEF_W-RB){1'b0}}, rand_data[RB-1:0]};
      r_accept_s = (r_cand_s < Q_C);
      s2_slot_s  = d_arith_s;
    end
  end

  mod_q_sub #(
    .KYBER_Q (KYBER_Q),
    .COEF_W  (COEF_W)
  ) u_mod_q_sub (
    .c_i (coef_red_s),
    .r_i (r_cand_s),
    .d_o (d_arith_s)
  );

  assign xfer_s = rand_valid && (state_q == MASK);

  // Next-state and share update logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    s_reg_d     = s_reg_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    range_err_d = range_err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = MASK;
          idx_d       = '0;
          s_reg_d     = s;
          s1_d        = '0;
          s2_d        = '0;
          range_err_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      MASK: begin
        // Rejected words are consumed without advancing idx.
        if (xfer_s && r_accept_s) begin
          s1_d[off_s -: COEF_W] = r_cand_s;
          s2_d[off_s -: COEF_W] = s2_slot_s;
          if (MODE == MODE_ARITH) begin
            range_err_d = range_err_q | coef_over_s;
          end else begin
            range_err_d = 1'b0;
          end
          if (idx_q == LAST) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = MASK;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and share registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      s_reg_q     <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      s_reg_q     <= s_reg_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      range_err_q <= range_err_d;
    end
  end

  assign rand_ready    = (state_q == MASK);
  assign busy          = (state_q != IDLE);
  assign function_done = (state_q == DONE);
  assign s1            = s1_q;
  assign s2            = s2_q;
  assign range_err     = range_err_q;

endmodule

// File: tb/tb_state_unpack_mask_n.sv
// Directed and randomised checks of state_unpack_mask_n in arithmetic (dut_a) and boolean (dut_b) modes.
module tb_state_unpack_mask_n;
  localparam int N  = 8;
  localparam int W  = 16;
  localparam int SW = N * W;
  localparam int Q  = 3329;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_a = 1'b0, start_b = 1'b0;
  logic [SW-1:0] s_a = '0, s_b = '0;
  logic [15:0]   rand_data = 16'd0;
  logic          rand_valid = 1'b0;

  logic          ready_a, busy_a, done_a, rerr_a;
  logic          ready_b, busy_b, done_b, rerr_b;
  logic [SW-1:0] s1_a, s2_a, s1_b, s2_b;

  int checks = 0;
  int errors = 0;
  logic [15:0] rq[$];
  logic [15:0] acc_q[$];
  int ready_drop;

  state_unpack_mask_n #(.KYBER_Q(Q), .COEF_W(W), .N_COEF(N), .RAND_W(16), .MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .s(s_a), .rand_data(rand_data),
    .rand_valid(rand_valid), .rand_ready(ready_a), .busy(busy_a), .function_done(done_a),
    .s1(s1_a), .s2(s2_a), .range_err(rerr_a)
  );

  state_unpack_mask_n #(.KYBER_Q(Q), .COEF_W(W), .N_COEF(N), .RAND_W(16), .MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .s(s_b), .rand_data(rand_data),
    .rand_valid(rand_valid), .rand_ready(ready_b), .busy(busy_b), .function_done(done_b),
    .s1(s1_b), .s2(s2_b), .range_err(rerr_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] slot(input logic [SW-1:0] v, input int i);
    return v[SW-1-i*W -: W];
  endfunction

  // Runs one operation; words come from rq while it lasts, random otherwise.
  // lat is the cycle (relative to the start cycle T) in which function_done was seen.
  task automatic run_op(input bit sel_b, input logic [SW-1:0] sv, input bit rnd_valid,
                        input int glitch_at, output int lat);
    logic rdy, xfer, dn;
    if (sel_b) begin s_b = sv; start_b = 1'b1; end
    else       begin s_a = sv; start_a = 1'b1; end
    rand_valid = 1'b0;
    acc_q.delete();
    ready_drop = 0;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    lat = 1;
    dn  = sel_b ? done_b : done_a;
    while (!dn && lat < 200) begin
      rand_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      rand_data  = (rq.size() > 0) ? rq[0] : 16'($urandom);
      if (lat == glitch_at) begin
        if (sel_b) begin start_b = 1'b1; s_b = ~sv; end
        else       begin start_a = 1'b1; s_a = ~sv; end
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      rdy = sel_b ? ready_b : ready_a;
      if (!rdy) ready_drop++;
      xfer = rand_valid && rdy;
      tick();
      if (xfer) begin
        if (rq.size() > 0) void'(rq.pop_front());
        if (sel_b) acc_q.push_back(rand_data);
        else if (rand_data[11:0] < 12'd3329) acc_q.push_back({4'h0, rand_data[11:0]});
      end
      lat++;
      dn = sel_b ? done_b : done_a;
    end
    check_eq("done_seen", dn, 1'b1);
    check_eq("acc_words_at_done", acc_q.size(), N);
    start_a = 1'b0;
    start_b = 1'b0;
    rand_valid = 1'b0;
    tick();
  endtask

  initial begin
    logic [SW-1:0] v1, exp_s1, exp_s2, recomb;
    int lat;

    // Reset state
    tick();
    check_eq("rst_s1", s1_a, '0);
    check_eq("rst_s2", s2_a, '0);
    check_eq("rst_flags", {busy_a, done_a, ready_a, rerr_a}, 4'b0000);
    rst_n = 1'b1;
    tick();

    // Arithmetic mode, rand = 200 for every word
    v1 = {16'd100, 16'd0, 16'd3328, 16'd1664, 16'd200, 16'd199, 16'd1, 16'd3000};
    rq.delete();
    repeat (N) rq.push_back(16'd200);
    run_op(1'b0, v1, 1'b0, -1, lat);
    check_eq("t1_latency", lat, 9);
    check_eq("t1_s1", s1_a, {N{16'd200}});
    check_eq("t1_s2", s2_a, {16'd3229, 16'd3129, 16'd3128, 16'd1464,
                             16'd0, 16'd3328, 16'd3130, 16'd2800});
    check_eq("t1_busy_after", {busy_a, done_a}, 2'b00);
    check_eq("t1_range_err", rerr_a, 1'b0);

    // Rejection: 0x0FFF and 0x0D01 rejected, upper nibble ignored, 0x0D00 accepted
    rq.delete();
    rq = '{16'h0FFF, 16'h0D01, 16'h0005, 16'hF005, 16'h0D00,
           16'h0005, 16'h0005, 16'h0005, 16'h0005, 16'h0005};
    run_op(1'b0, {N{16'd10}}, 1'b0, -1, lat);
    check_eq("t2_latency", lat, 11);
    check_eq("t2_ready_held", ready_drop, 0);
    check_eq("t2_s1", s1_a, {16'd5, 16'd5, 16'd3328, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5});
    check_eq("t2_s2", s2_a, {16'd5, 16'd5, 16'd11, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5});

    // Out-of-range coefficients: one subtract of Q, sticky range_err
    rq.delete();
    repeat (N) rq.push_back(16'd0);
    run_op(1'b0, {16'd7, 16'd7, 16'd7, 16'd3400, 16'd7, 16'd3329, 16'd7, 16'd3328},
           1'b0, -1, lat);
    check_eq("t3_range_err", rerr_a, 1'b1);
    check_eq("t3_s2", s2_a, {16'd7, 16'd7, 16'd7, 16'd71, 16'd7, 16'd0, 16'd7, 16'd3328});
    check_eq("t3_s1", s1_a, '0);

    // In-range operation after that clears range_err
    rq.delete();
    repeat (N) rq.push_back(16'd200);
    run_op(1'b0, v1, 1'b0, -1, lat);
    check_eq("t4_range_err_cleared", rerr_a, 1'b0);

    // Boolean mode: 0xFFFF00FF truncated to the 16-bit port is 0x00FF
    rq.delete();
    repeat (N) rq.push_back(16'h00FF);
    run_op(1'b1, {16'h1234, 16'hFFFF, 16'hABCD, 16'h0000, 16'h00FF, 16'h0F0F, 16'h8000, 16'h0001},
           1'b0, -1, lat);
    check_eq("t5_latency", lat, 9);
    check_eq("t5_s1", s1_b, {N{16'h00FF}});
    check_eq("t5_s2", s2_b, {16'h12CB, 16'hFF00, 16'hAB32, 16'h00FF,
                             16'h0000, 16'h0FF0, 16'h80FF, 16'h00FE});
    check_eq("t5_range_err", rerr_b, 1'b0);

    // start while busy plus a change on s: must not disturb the running operation
    rq.delete();
    repeat (N) rq.push_back(16'd200);
    run_op(1'b0, v1, 1'b0, 3, lat);
    check_eq("t6_latency", lat, 9);
    check_eq("t6_s2", s2_a, {16'd3229, 16'd3129, 16'd3128, 16'd1464,
                             16'd0, 16'd3328, 16'd3130, 16'd2800});
    check_eq("t6_idle_after", busy_a, 1'b0);

    // Reset asserted with idx = 4
    rq.delete();
    s_a = v1;
    rand_data = 16'd1;
    rand_valid = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (4) tick();
    check_eq("t7_partial_s1", slot(s1_a, 3), 16'd1);
    check_eq("t7_busy_pre", busy_a, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t7_rst_s1", s1_a, '0);
    check_eq("t7_rst_s2", s2_a, '0);
    check_eq("t7_rst_flags", {busy_a, done_a, ready_a, rerr_a}, 4'b0000);
    repeat (2) tick();
    rst_n = 1'b1;
    rand_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check_eq("t7_no_done", {busy_a, done_a}, 2'b00);
    end

    // Randomised: s in [0, Q), random words, rand_valid toggling
    rq.delete();
    for (int op = 0; op < 1000; op++) begin
      for (int i = 0; i < N; i++) v1[SW-1-i*W -: W] = 16'($urandom_range(0, Q - 1));
      run_op(1'b0, v1, 1'b1, -1, lat);
      exp_s1 = '0;
      exp_s2 = '0;
      recomb = '0;
      for (int i = 0; i < N && i < acc_q.size(); i++) begin
        exp_s1[SW-1-i*W -: W] = acc_q[i];
        exp_s2[SW-1-i*W -: W] = 16'((int'(slot(v1, i)) - int'(acc_q[i]) + Q) % Q);
        recomb[SW-1-i*W -: W] = 16'((int'(slot(s1_a, i)) + int'(slot(s2_a, i))) % Q);
      end
      check_eq("rnd_s1", s1_a, exp_s1);
      check_eq("rnd_s2", s2_a, exp_s2);
      check_eq("rnd_recombine", recomb, v1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
